// File: rtl/mac_pkg.sv
// Shared constants and types for the FP8 x SD4 accumulating MAC pipeline.
package mac_pkg;

    // Operand formats: image is E4M3-style {s, e[3:0], m[2:0]}, weight is signed 4-bit.
    localparam int IMG_W = 8;
    localparam int WGT_W = 4;
    localparam int E_W   = 4;
    localparam int M_W   = 3;
    localparam int EB_W  = 5;

    // Unsigned product {1,m} x |w|.
    localparam int MAG_W = M_W + 1 + WGT_W;

    // FP16 output format.
    localparam int          FP16_EXP_W   = 5;
    localparam int          FP16_MAN_W   = 10;
    localparam int          FP16_BIAS    = 15;
    localparam logic [15:0] FP16_MAX_FIN = 16'h7BFF;

    // Accumulator LSB carries weight 2^ACC_LSB_EXP.
    localparam int ACC_LSB_EXP = -10;

    // Control sideband that travels alongside every pipeline stage.
    typedef struct packed {
        logic            valid;
        logic            first;
        logic            last;
        logic [EB_W-1:0] exp_bias;
    } sb_t;

endpackage

// File: rtl/mac_stage_acc_if.sv
// Beat-in / result-out handshake bundle of the accumulating MAC stage.
interface mac_stage_acc_if #(parameter int TAPS = 9);
    import mac_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_first;
    logic                    in_last;
    logic [TAPS*IMG_W-1:0]   image;
    logic [TAPS*WGT_W-1:0]   weight;
    logic [EB_W-1:0]         exp_bias;
    logic                    out_valid;
    logic                    out_ready;
    logic [15:0]             out;

    // Feeder / writeback side.
    modport master (
        output in_valid, in_first, in_last, image, weight, exp_bias, out_ready,
        input  in_ready, out_valid, out
    );

    // MAC side.
    modport slave (
        input  in_valid, in_first, in_last, image, weight, exp_bias, out_ready,
        output in_ready, out_valid, out
    );

endinterface

// File: rtl/mac_norm_fp16.sv
// Converts a signed fixed-point accumulator (LSB = 2^-10) to FP16 with a
// caller-supplied exponent shift. Purely combinational; the parent registers it.
module mac_norm_fp16
    import mac_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [EB_W-1:0]  i_exp_bias,
    output logic [15:0]      o_fp16
);

    logic                  w_sign;
    logic [ACC_W-1:0]      w_mag;
    int                    w_p;
    int                    w_e;
    logic [FP16_MAN_W-1:0] w_mant;

    // Unsigned magnitude, so the most negative value maps to 2^(ACC_W-1).
    assign w_sign = i_acc[ACC_W-1];
    assign w_mag  = w_sign ? -i_acc : i_acc;

    // Leading-one detect: highest set bit wins.
    // NOTE: every always_comb output gets a default before any conditional write; otherwise a latch is inferred.
    always_comb begin
        w_p = 0;
        for (int i = 0; i < ACC_W; i++) begin
            if (w_mag[i]) w_p = i;
        end
    end

    assign w_e = w_p + FP16_BIAS + ACC_LSB_EXP - int'(i_exp_bias);

    // Mantissa: the bits just below the leading one, zero-filled past bit 0.
    always_comb begin
        w_mant = '0;
        for (int k = 0; k < FP16_MAN_W; k++) begin
            if (w_p - 1 - k >= 0) w_mant[FP16_MAN_W-1-k] = w_mag[w_p-1-k];
        end
    end

    // Pack, saturating to the largest finite value and flushing underflow to signed zero.
    always_comb begin
        if (i_acc == '0) begin
            o_fp16 = 16'h0000;
        end else if (w_e >= (1 << FP16_EXP_W) - 1) begin
            o_fp16 = {w_sign, FP16_MAX_FIN[14:0]};
        end else if (w_e <= 0) begin
            o_fp16 = {w_sign, 15'b0};
        end else begin
            o_fp16 = {w_sign, w_e[FP16_EXP_W-1:0], w_mant};
        end
    end

endmodule

// File: rtl/mac_stage_acc.sv
// Five-stage FP8 x SD4 MAC with packet accumulation:
// product -> align -> reduce -> accumulate -> normalise to FP16.
// One global enable stalls every stage while a result waits to be taken.
module mac_stage_acc
    import mac_pkg::*;
#(
    parameter int TAPS  = 9,
    parameter int ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mac_stage_acc_if.slave     bus
);

    logic             w_en;
    sb_t              w_sb0;

    // S1 product
    logic [MAG_W-1:0] w_mag [TAPS];
    logic             w_neg [TAPS];
    logic [E_W-1:0]   w_exp [TAPS];
    sb_t              r_sb1;
    logic [MAG_W-1:0] r_mag [TAPS];
    logic             r_neg [TAPS];
    logic [E_W-1:0]   r_exp [TAPS];

    // S2 align
    logic [ACC_W-1:0] w_shift [TAPS];
    logic [ACC_W-1:0] w_term  [TAPS];
    sb_t              r_sb2;
    logic [ACC_W-1:0] r_term  [TAPS];

    // S3 reduce
    logic [ACC_W-1:0] w_sum;
    sb_t              r_sb3;
    logic [ACC_W-1:0] r_sum;

    // S4 accumulate
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_s4_valid;
    logic [EB_W-1:0]  r_s4_bias;
    logic [ACC_W-1:0] r_s4_val;

    // S5 output
    logic [15:0]      w_fp16;
    logic             r_out_valid;
    logic [15:0]      r_out;

    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;

    assign w_sb0 = '{valid: bus.in_valid, first: bus.in_first,
                     last: bus.in_last, exp_bias: bus.exp_bias};

    for (genvar g = 0; g < TAPS; g++) begin : g_tap
        logic [IMG_W-1:0] w_img;
        logic [WGT_W-1:0] w_wgt;
        logic [WGT_W-1:0] w_wabs;

        assign w_img  = bus.image[IMG_W*g +: IMG_W];
        assign w_wgt  = bus.weight[WGT_W*g +: WGT_W];
        // |-8| = 8 still fits in 4 unsigned bits.
        assign w_wabs = w_wgt[WGT_W-1] ? -w_wgt : w_wgt;

        assign w_exp[g] = w_img[IMG_W-2 -: E_W];
        assign w_neg[g] = w_img[IMG_W-1] ^ w_wgt[WGT_W-1];
        // e == 0 is flushed to zero; w == 0 gives zero on its own.
        assign w_mag[g] = (w_exp[g] == '0) ? '0
                        : MAG_W'({1'b1, w_img[M_W-1:0]}) * MAG_W'(w_wabs);

        // Exact absolute alignment: value = mag * 2^(e-10), i.e. mag << e in LSB units.
        assign w_shift[g] = ACC_W'(r_mag[g]) << r_exp[g];
        assign w_term[g]  = r_neg[g] ? -w_shift[g] : w_shift[g];
    end

    // Full-precision tree sum of the aligned terms (modular two's complement).
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < TAPS; i++) w_sum = w_sum + r_term[i];
    end

    assign w_acc_next = (r_sb3.first ? '0 : r_acc) + r_sum;

    // S1..S3 data and sideband registers, all held together under stall.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb1  <= '0;
            r_sb2  <= '0;
            r_sb3  <= '0;
            r_mag  <= '{default: '0};
            r_neg  <= '{default: 1'b0};
            r_exp  <= '{default: '0};
            r_term <= '{default: '0};
            r_sum  <= '0;
        end else if (w_en) begin
            r_sb1  <= w_sb0;
            r_mag  <= w_mag;
            r_neg  <= w_neg;
            r_exp  <= w_exp;
            r_sb2  <= r_sb1;
            r_term <= w_term;
            r_sb3  <= r_sb2;
            r_sum  <= w_sum;
        end
    end

    // S4: running packet sum; a last beat forwards the total and clears the accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_s4_valid <= 1'b0;
            r_s4_bias  <= '0;
            r_s4_val   <= '0;
        end else if (w_en) begin
            r_s4_valid <= r_sb3.valid && r_sb3.last;
            if (r_sb3.valid) begin
                r_s4_val  <= w_acc_next;
                r_s4_bias <= r_sb3.exp_bias;
                r_acc     <= r_sb3.last ? '0 : w_acc_next;
            end
        end
    end

    mac_norm_fp16 #(.ACC_W(ACC_W)) u_norm (
        .i_acc      (r_s4_val),
        .i_exp_bias (r_s4_bias),
        .o_fp16     (w_fp16)
    );

    // S5: registered FP16 result; held unchanged while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out       <= 16'h0000;
        end else if (w_en) begin
            r_out_valid <= r_s4_valid;
            if (r_s4_valid) r_out <= w_fp16;
        end
    end

endmodule

// File: tb/tb_mac_stage_acc.sv
// Scoreboard bench for mac_stage_acc: a driver pushes expected FP16 results,
// an independent monitor pops and compares whenever a result is handed over.
module tb_mac_stage_acc;

    localparam int TAPS  = 9;
    localparam int ACC_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_stage_acc_if #(.TAPS(TAPS)) bif ();

    mac_stage_acc #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_out_cyc = 0;
    int          rdy_mode = 0;       // 0: always ready, 1: random, 2: held low
    longint      model_acc = 0;
    logic [15:0] exp_q [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference value of one beat in units of 2^-10: sum of (-1)^s * (8+m) * w * 2^e.
    function automatic longint beat_value(logic [TAPS*8-1:0] img, logic [TAPS*4-1:0] wgt);
        longint s = 0;
        for (int i = 0; i < TAPS; i++) begin
            logic [7:0]        b;
            logic signed [3:0] w4;
            int                e, m, w;
            longint            v;
            b  = img[8*i +: 8];
            w4 = wgt[4*i +: 4];
            e  = b[6:3];
            m  = b[2:0];
            w  = w4;
            if (e != 0) begin
                v = longint'((8 + m) * w) * (longint'(1) << e);
                if (b[7]) v = -v;
                s += v;
            end
        end
        return s;
    endfunction

    // FP16 of (acc * 2^-10) scaled by 2^-bias, truncating, saturating, flushing.
    function automatic logic [15:0] fp16_of(longint acc, int bias);
        longint      a, mag;
        int          p, e;
        logic        s;
        logic [9:0]  frac;
        logic [4:0]  ef;
        a = longint'(int'(acc));
        if (a == 0) return 16'h0000;
        s   = (a < 0);
        mag = s ? -a : a;
        p   = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = (p - 10) + 15 - bias;
        if (e >= 31) return {s, 15'h7BFF};
        if (e <= 0)  return {s, 15'h0000};
        frac = 10'(((mag << 10) >> p) - (longint'(1) << 10));
        ef   = 5'(e);
        return {s, ef, frac};
    endfunction

    function automatic logic [TAPS*8-1:0] rep_img(logic [7:0] v);
        logic [TAPS*8-1:0] r;
        for (int i = 0; i < TAPS; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    function automatic logic [TAPS*4-1:0] rep_wgt(logic [3:0] v);
        logic [TAPS*4-1:0] r;
        for (int i = 0; i < TAPS; i++) r[4*i +: 4] = v;
        return r;
    endfunction

    // Present one beat and wait (bounded) for acceptance. Leaves in_valid high.
    // dir=1 pushes the literal dexp on the last beat instead of the model result.
    task automatic send_beat(input bit f, input bit l, input logic [TAPS*8-1:0] img,
                             input logic [TAPS*4-1:0] wgt, input logic [4:0] eb,
                             input bit dir, input logic [15:0] dexp);
        int n = 0;
        bif.in_valid = 1'b1;
        bif.in_first = f;
        bif.in_last  = l;
        bif.image    = img;
        bif.weight   = wgt;
        bif.exp_bias = eb;
        do begin
            @(negedge clk);
            n++;
        end while (!bif.in_ready && n < 200);
        if (!bif.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
            bif.in_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (dir) begin
            if (l) exp_q.push_back(dexp);
        end else begin
            if (f) model_acc = 0;
            model_acc += beat_value(img, wgt);
            if (l) begin
                exp_q.push_back(fp16_of(model_acc, int'(eb)));
                model_acc = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        bif.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        bif.in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic run_random(input int npkt);
        for (int p = 0; p < npkt; p++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                logic [TAPS*8-1:0] img;
                logic [TAPS*4-1:0] wgt;
                logic [4:0]        eb;
                bit                f;
                for (int i = 0; i < TAPS; i++) begin
                    img[8*i +: 8] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                    wgt[4*i +: 4] = 4'($urandom);
                end
                eb = 5'($urandom_range(4, 26));
                f  = (b == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
                send_beat(f, b == nb - 1, img, wgt, eb, 1'b0, 16'h0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        bif.in_valid = 1'b0;
    endtask

    // Consumer-side ready pattern, updated just after each rising edge.
    initial begin
        bif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bif.out_ready = 1'b1;
                1:       bif.out_ready = ($urandom_range(0, 9) < 7);
                default: bif.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare each handed-over result and check hold-stability under stall.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_out;
        logic [15:0] e;
        prev_stall = 1'b0;
        prev_out   = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", bif.out_valid, 1);
                    check("hold_out", bif.out, prev_out);
                end
                if (bif.out_valid && bif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %h with no result pending", bif.out);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", bif.out, e);
                        last_out_cyc = cyc;
                    end
                end
                prev_stall = bif.out_valid && !bif.out_ready;
                prev_out   = bif.out;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAPS*8-1:0] img_one, img_38, img_7f, img_sgn, img_flush;
        logic [TAPS*4-1:0] w_one, w_1, w_3, w_7, w_sgn, w_flush;
        int                n;

        img_one   = 72'h38;     w_one   = 36'h1;
        img_sgn   = 72'h38B8;   w_sgn   = 36'h87;
        img_flush = 72'h3801;   w_flush = 36'h17;
        img_38    = rep_img(8'h38);
        img_7f    = rep_img(8'h7F);
        w_1       = rep_wgt(4'h1);
        w_3       = rep_wgt(4'h3);
        w_7       = rep_wgt(4'h7);

        bif.in_valid = 1'b0;
        bif.in_first = 1'b0;
        bif.in_last  = 1'b0;
        bif.image    = '0;
        bif.weight   = '0;
        bif.exp_bias = '0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_out", bif.out, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", bif.in_ready, 1);

        // Single-beat 1.0 and its latency.
        send_beat(1, 1, img_one, w_one, 5'd0, 1, 16'h3C00);
        drain();
        check("latency", last_out_cyc - acc_cyc, 5);

        // Three-beat accumulation to 27.0.
        send_beat(1, 0, img_38, w_1, 5'd0, 1, 16'h0);
        send_beat(0, 0, img_38, w_1, 5'd0, 1, 16'h0);
        send_beat(0, 1, img_38, w_1, 5'd0, 1, 16'h4EC0);
        drain();

        // Signed sum, saturation, underflow flush, e==0 flush.
        send_beat(1, 1, img_sgn, w_sgn, 5'd0, 1, 16'hCB80);
        send_beat(1, 0, img_7f, w_7, 5'd0, 1, 16'h0);
        send_beat(0, 0, img_7f, w_7, 5'd0, 1, 16'h0);
        send_beat(0, 1, img_7f, w_7, 5'd0, 1, 16'h7BFF);
        send_beat(1, 1, img_one, w_one, 5'd31, 1, 16'h0000);
        send_beat(1, 1, img_flush, w_flush, 5'd0, 1, 16'h3C00);
        drain();

        // Backpressure: consumer stalls for 4 cycles with two results in flight.
        rdy_mode = 2;
        @(posedge clk);
        #2;
        send_beat(1, 1, img_one, w_one, 5'd0, 1, 16'h3C00);
        send_beat(1, 1, img_38, w_3, 5'd0, 1, 16'h4EC0);
        bif.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bif.out_valid && n < 50);
        check("bp_valid_seen", bif.out_valid, 1);
        repeat (4) begin
            check("bp_in_ready", bif.in_ready, 0);
            check("bp_out", bif.out, 16'h3C00);
            @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        // Reset in the middle of a packet; the partial sum must be discarded.
        send_beat(1, 0, img_38, w_1, 5'd0, 1, 16'h0);
        send_beat(0, 0, img_38, w_1, 5'd0, 1, 16'h0);
        bif.in_valid = 1'b0;
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_out_valid", bif.out_valid, 0);
            check("midrst_out", bif.out, 0);
        end
        rst = 1'b1;
        model_acc = 0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", bif.in_ready, 1);
        send_beat(0, 1, img_one, w_one, 5'd0, 1, 16'h3C00);
        drain();

        // Randomised packets with random consumer backpressure.
        rdy_mode = 1;
        run_random(40);
        rdy_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_stage_acc.md
Name: mac_stage_acc

Overview:
Parametrised successor of the fixed 9-tap, 5-stage FP8×SD4 MAC pipeline. Takes TAPS image/weight pairs per beat and sums them. Accumulates partial sums over a multi-beat packet framed by in_first/in_last, so kernels or channel counts larger than TAPS are supported. Emits one FP16 result per packet, with valid/ready handshakes on both sides and full backpressure. Sits between the line-buffer/weight feeder and the output writeback.

Parameters:
TAPS, 9, products summed per beat
ACC_W, 32, signed fixed-point accumulator width; LSB weight 2^-10; must be ≥ 23+clog2(TAPS×max beats)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_first  in  1  first beat of packet; accumulator restarts from 0
in_last  in  1  last beat of packet; result emitted
image  in  TAPS*8  element i = image[8i+7:8i] = {s, e[3:0], m[2:0]}
weight  in  TAPS*4  element i = weight[4i+3:4i], two's complement, −8..7
exp_bias  in  5  output scale shift, sampled with the last beat
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out  out  16  FP16 result

Behaviour:
- Image element value: e==0 → 0 (flush, no subnormals); otherwise (−1)^s × 1.mmm × 2^(e−7).
- Stage 1 (S1), product:
  - mag_i = {1,m}(4b) × |w|(4b) → 8 bits; e==0 or w==0 gives 0.
  - Product sign = s XOR w[3].
- Stage 2 (S2), align: term_i = ±(mag_i << e_i), sign-extended to ACC_W. The absolute alignment is exact, so no per-beat exp_max is needed.
- Stage 3 (S3), reduce: sum = Σ term_i over all TAPS, full precision, ACC_W.
- Stage 4 (S4), accumulate:
  - On a valid beat: acc ← (first ? 0 : acc) + sum.
  - On a valid last beat, acc+sum is forwarded to S5 and acc is cleared to 0.
  - A beat without in_first after a last beat therefore starts from 0.
  - Overflow wraps; sizing ACC_W correctly is the integrator's job.
- Stage 5 (S5), normalise/pack into a register:
  - acc==0 → 0x0000.
  - Otherwise sign = acc MSB and mag = |acc| (unsigned ACC_W, so −2^(ACC_W−1) is handled).
  - p = index of the leading one of mag; E = p + 5 − exp_bias, computed as signed.
  - E ≥ 31 → saturate to {sign, 0x7BFF[14:0]}.
  - E ≤ 0 → {sign, 15'b0}.
  - Otherwise mantissa = the 10 bits below the leading one, truncated and zero-filled when p < 10.
- Control:
  - Global stall: en = !out_valid || out_ready; in_ready = en.
  - Each stage holds a valid bit plus first/last/exp_bias sideband. All stage registers load only when en.
  - Only last-beat results set out_valid; non-last beats never raise out_valid.
- Latency: last beat accepted at cycle t → out_valid at t+5 when there are no stalls. Throughput is 1 beat/cycle.
- out and out_valid stay stable while out_valid && !out_ready.
- Reset (rst low, any time, including mid-packet):
  - All stage valids and out_valid = 0; out = 0x0000; acc = 0.
  - in_ready = 1 from the first clock after release.
  - A partial packet is discarded.
- If in_first and in_last are both set, the packet is a single beat.

Decomposition:
- Package mac_pkg:
  - IMG_W=8, WGT_W=4, E4M3 field widths
  - FP16_MAX_FIN=16'h7BFF, FP16 bias 15, ACC_LSB_EXP=−10
  - typedef of the stage-sideband struct {valid, first, last, exp_bias}
- Sub-module mac_norm_fp16: combinational leading-one detect plus pack (S5 logic), registered by the parent.

Test Plan:
- Single-beat 1.0: tap0 image=8'h38, weight=4'h1, other taps 0, exp_bias=0, first=last=1 → out=16'h3C00, out_valid exactly 5 cycles after acceptance.
- Three-beat accumulation: every beat has all 9 taps image=8'h38, weight=4'h1; first on beat 0, last on beat 2 → one result 16'h4EC0 (27.0); no out_valid for beats 0 and 1.
- Signed sum: tap0 image=8'hB8, w=4'h7; tap1 image=8'h38, w=4'h8; single beat → 16'hCB80 (−15.0).
- Saturation and flush:
  - Three beats of all taps image=8'h7F, w=4'h7 → 16'h7BFF.
  - 1.0 with exp_bias=31 → 16'h0000.
  - image=8'h01 (e=0) → contributes 0.
- Backpressure: two back-to-back single-beat packets (1.0, then 27.0 via weight=4'h3 on 9 taps) with out_ready held low for 4 cycles:
  - in_ready drops.
  - out stays 16'h3C00.
  - Results are then delivered in order with none lost.
- Reset mid-packet: assert rst after 2 non-last beats, release, then send a single-beat 1.0 → out=16'h3C00 (no residual accumulation); all outputs 0 during reset.
